pc_step_unit: RTL

Parametrised program-counter unit for the KGP-RISC fetch stage. It holds the registered PC and advances it by a configurable step each cycle. It loads branch/jump targets and supports stalls. A small return-address stack (RAS) handles call/return without a register-file round trip. It replaces the fixed 32-bit, +4 combinational incrementer in the fetch path.

---
 rtl/pc_step_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/pc_step_unit.sv
// Fetch-stage program counter with a configurable sequential step, branch/call/return
// redirection, stall support and a small LIFO return-address stack.
module pc_step_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_PC  = {WIDTH{1'b0}},
  parameter int unsigned      RAS_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             call_en,
  input  logic             ret_en,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_seq,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam int unsigned      IW      = $clog2(RAS_DEPTH);
  localparam int unsigned      CW      = IW + 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(RAS_DEPTH);
  localparam logic [WIDTH-1:0] STEP_C  = WIDTH'(STEP);

  logic [WIDTH-1:0] pc_r;
  logic [CW-1:0]    count_r;
  logic             err_r;
  logic [WIDTH-1:0] stack_r [RAS_DEPTH];

  logic [WIDTH-1:0] pc_seq_s;
  logic [WIDTH-1:0] next_pc_s;
  logic [CW-1:0]    next_count_s;
  logic             next_err_s;
  logic             push_s;
  logic             empty_s;
  logic             full_s;
  logic [IW-1:0]    top_idx_s;
  logic [IW-1:0]    push_idx_s;

  // Wrap-around of the sequential PC is intentional and silent.
  assign pc_seq_s   = pc_r + STEP_C;
  assign empty_s    = (count_r == {CW{1'b0}});
  assign full_s     = (count_r == DEPTH_C);
  assign top_idx_s  = IW'(count_r - CW'(1));
  assign push_idx_s = count_r[IW-1:0];

  assign pc        = pc_r;
  assign pc_seq    = pc_seq_s;
  assign ras_empty = empty_s;
  assign ras_full  = full_s;
  assign ras_err   = err_r;

  // Next-state selection: stall > ret > call > branch > sequential, one RAS op per cycle.
  always_comb begin
    next_pc_s    = pc_seq_s;
    next_count_s = count_r;
    next_err_s   = err_r;
    push_s       = 1'b0;
    if (stall) begin
      next_pc_s = pc_r;
    end else if (ret_en) begin
      if (!empty_s) begin
        next_pc_s    = stack_r[top_idx_s];
        next_count_s = count_r - CW'(1);
      end else begin
        next_err_s = 1'b1;
      end
    end else if (call_en) begin
      next_pc_s = branch_target;
      if (!full_s) begin
        push_s       = 1'b1;
        next_count_s = count_r + CW'(1);
      end else begin
        next_err_s = 1'b1;
      end
    end else if (branch_en) begin
      next_pc_s = branch_target;
    end else begin
      next_pc_s = pc_seq_s;
    end
  end

  // Control state: PC, stack depth and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r    <= RESET_PC;
      count_r <= {CW{1'b0}};
      err_r   <= 1'b0;
    end else begin
      pc_r    <= next_pc_s;
      count_r <= next_count_s;
      err_r   <= next_err_s;
    end
  end

  // Stack storage; contents are don't-care after reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      stack_r[push_idx_s] <= pc_seq_s;
    end
  end

endmodule
